mux2_arbiter: RTL
=================

Name: mux2_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one mux2 datapath between two requesters.
- Drives the mux select `sel` and per-requester grants.
- Inserts programmable settle cycles after every select change, so the gate-level mux output (multi-gate propagation delay) is stable before `out_valid` asserts.
- Sits between the two requesting sources and the mux2 instance; `sel` connects directly to the mux select input.

Parameters:
- SETTLE_CYCLES, 1, dead cycles after a `sel` change before grant/out_valid assert (0 = none; legal 0..15).
- MAX_HOLD, 8, max consecutive granted cycles for one owner while the other requester is waiting (legal 1..255).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  2  req[i]=1 requests the datapath for requester i (i = 0 → d0, i = 1 → d1).
- gnt  output  2  one-hot-or-zero grant; gnt[i]=1 means requester i owns the mux this cycle.
- sel  output  1  mux select (0 → d0, 1 → d1).
- out_valid  output  1  mux output is settled and owned; equals |gnt.
- owner  output  1  index of current/last owner (debug/observability).

Behaviour:
- All outputs registered. Reset (rst_n=0, async) forces:
  - state=IDLE, sel=0, gnt=00, out_valid=0, owner=1 (so requester 0 wins the first tie).
  - hold and settle counters = 0.
- Reset mid-operation aborts immediately. No grant persists after rst_n rises.
- Winner function (evaluated on req sampled at the edge):
  - both set → ~owner;
  - one set → that one;
  - none → no winner.
- State IDLE:
  - gnt=00.
  - On an edge with a winner w:
    - if w==sel, or SETTLE_CYCLES==0: set sel=w, owner=w, gnt[w]=1, hold=1, go GRANT.
    - else: set sel=w, owner=w, settle=SETTLE_CYCLES, go SWITCH.
- State SWITCH:
  - gnt=00, out_valid=0. settle decrements each edge.
  - On the edge where settle==1:
    - if req[owner]==1: gnt[owner]=1, hold=1, go GRANT.
    - else: go IDLE with sel unchanged.
  - A request from the other requester during SWITCH is ignored until the next arbitration.
- State GRANT:
  - gnt[owner]=1, out_valid=1. Each edge evaluates, in priority order:
    1. req[owner]==0 → release:
       - if req[~owner]==1: switch to ~owner (SWITCH, or straight GRANT with hold=1 if SETTLE_CYCLES==0);
       - else: gnt=00, go IDLE.
    2. hold==MAX_HOLD and req[~owner]==1 → forced release; switch to ~owner as above.
    3. hold==MAX_HOLD and req[~owner]==0 → stay GRANT, hold=1 (no bubble).
    4. else hold=hold+1 (saturating width 8 bits; never exceeds MAX_HOLD).
- Latency (req rising before edge k):
  - no select change → gnt visible after edge k;
  - select change → gnt after edge k+SETTLE_CYCLES.
- Invariants:
  - gnt never 11.
  - sel never changes while gnt!=00.
  - out_valid==|gnt.
  - sel==owner whenever gnt!=00.
- Simultaneous:
  - both req rise on the same edge → tie to ~owner.
  - owner drops req on the same edge hold hits MAX_HOLD → rule 1 (normal release).
- Unused states decode to IDLE.

Test Plan:
- Reset: rst_n=0 asserted mid-GRANT, asynchronous between edges → gnt=00, sel=0, out_valid=0, owner=1 immediately, without waiting for a clock edge.
- Single requester, no switch (SETTLE_CYCLES=1): after reset, req=01 at edge 1, held 5 cycles then dropped → gnt=01 from edge 1 for 5 cycles, sel stays 0, then gnt=00, IDLE.
- Switch settle (SETTLE_CYCLES=2): req=10 from IDLE with sel=0 → sel=1 after edge k, gnt=00 for 2 cycles, gnt=10 and out_valid=1 after edge k+2.
- Fairness/MAX_HOLD=4: req=11 held continuously from reset with SETTLE_CYCLES=1.
  - Expect gnt=01 ×4, 00 ×1 (sel→1), 10 ×4, 00 ×1 (sel→0), repeating.
  - Check gnt never 11 and sel stable while gnt!=00.
- No-contention extension (MAX_HOLD=4): req=01 for 10 cycles → gnt=01 for all 10 cycles, no bubble at hold wrap.
- Abort in SWITCH (SETTLE_CYCLES=3): req=10 for 1 cycle only → sel=1, gnt stays 00, return to IDLE after 3 cycles.
  - Subsequent req=01 → sel=0 after the next edge, gnt=01 after 3 more cycles.

Source files
------------

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin owner of a shared mux2 with settle cycles after every select change
module mux2_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_HOLD      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       out_valid,
    output logic       owner
);
    typedef enum logic [1:0] {IDLE, SWITCH, GRANT} state_t;

    state_t     state, state_nx;
    logic [1:0] gnt_nx;
    logic       sel_nx, owner_nx, go, tgt, win;
    logic [7:0] hold, hold_nx;
    logic [3:0] settle, settle_nx;

    assign win = &req ? ~owner : req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            owner     <= 1'b1;
            hold      <= 8'd0;
            settle    <= 4'd0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            sel       <= sel_nx;
            out_valid <= |gnt_nx;
            owner     <= owner_nx;
            hold      <= hold_nx;
            settle    <= settle_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        sel_nx    = sel;
        owner_nx  = owner;
        hold_nx   = hold;
        settle_nx = settle;
        go        = 1'b0;
        tgt       = owner;
        case (state)
            IDLE: begin
                gnt_nx = 2'b00;
                if (|req) begin
                    go  = 1'b1;
                    tgt = win;
                end
            end
            SWITCH: begin
                gnt_nx    = 2'b00;
                settle_nx = settle - 4'd1;
                if (settle <= 4'd1) begin
                    state_nx = req[owner] ? GRANT : IDLE;
                    gnt_nx   = req[owner] ? {owner, ~owner} : 2'b00;
                    hold_nx  = req[owner] ? 8'd1 : hold;
                end
            end
            GRANT: begin
                if (!req[owner] || hold >= 8'(MAX_HOLD)) begin
                    if (req[~owner]) begin
                        go  = 1'b1;
                        tgt = ~owner;
                    end else if (!req[owner]) begin
                        gnt_nx   = 2'b00;
                        state_nx = IDLE;
                    end else begin
                        hold_nx = 8'd1;
                    end
                end else begin
                    hold_nx = hold + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 2'b00;
            end
        endcase
        // a new owner either reuses the current select or waits out the settle window
        if (go) begin
            sel_nx   = tgt;
            owner_nx = tgt;
            if (tgt == sel || SETTLE_CYCLES == 0) begin
                gnt_nx   = {tgt, ~tgt};
                hold_nx  = 8'd1;
                state_nx = GRANT;
            end else begin
                gnt_nx    = 2'b00;
                settle_nx = 4'(SETTLE_CYCLES);
                state_nx  = SWITCH;
            end
        end
    end
endmodule
